cv32e40s_fetch_req_ctrl: RTL and testbench

//  Prefetch request controller that sits directly upstream of the instruction OBI adapter.
//  - Generates word-aligned sequential fetch addresses and drives the trans_* request side.
//  - Limits outstanding transactions with a credit scheme.
//  - Buffers responses in a small FIFO and discards stale responses after a branch/kill.
//  - Presents fetched words to the alignment stage on a valid/ready interface.
//

---
 rtl/cv32e40s_pkg.sv | 20 ++
 rtl/cv32e40s_fetch_fifo.sv | 56 +++++
 rtl/cv32e40s_fetch_req_ctrl.sv | 128 ++++++++++++
 tb/tb_cv32e40s_fetch_req_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types for the instruction fetch front end: the buffered fetch entry and small helpers.
package cv32e40s_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_ENTRY_RESET_VAL = '{rdata: 32'h0, addr: 32'h0, err: 1'b0};

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p == depth - 1) ? 32'd0 : p + 32'd1;
  endfunction

endpackage

// File: rtl/cv32e40s_fetch_fifo.sv
// Fetch response FIFO: DEPTH-entry synchronous queue with flush; head reads 0 while empty.
// Latency: a push is visible on head the following cycle (no bypass).
// Backpressure: none internally; the caller's credit scheme guarantees no push into a full FIFO.
module cv32e40s_fetch_fifo
  import cv32e40s_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       empty,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign cnt    = cnt_q;
  assign head   = empty ? FETCH_ENTRY_RESET_VAL : mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push)   wr_q <= AW'(wrap_inc(32'(wr_q), DEPTH));
      if (do_pop) rd_q <= AW'(wrap_inc(32'(rd_q), DEPTH));
      cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/cv32e40s_fetch_req_ctrl.sv
// Fetch request controller: word-sequential OBI requests, credit-limited, stale responses dropped after branch (option CV32E40S_FETCH_STOP_ON_ERR_EN stops fetching after a bus error).
// Latency: response visible on fetch_* one cycle after resp_valid_i; first request the cycle after branch_i.
// Backpressure: trans_* held until accepted; responses never stalled; fetch_ready_i low throttles requests via credit.
module cv32e40s_fetch_req_ctrl
  import cv32e40s_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prefetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        trans_valid_o,
  input  logic        trans_ready_i,
  output logic [31:0] trans_addr_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i,
  input  logic        resp_err_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o,
  output logic        busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   addr_q;
  logic          started_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] outst_next;
  logic [CW-1:0] discard_q;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   credit_used;
  logic [31:0]   iaq_q [DEPTH];
  logic [AW-1:0] iaq_wr_q;
  logic [AW-1:0] iaq_rd_q;
  logic          accept;
  logic          push;
  logic          pop;
  logic          stop;
  logic          fifo_empty;
  logic          fifo_full;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

`ifdef CV32E40S_FETCH_STOP_ON_ERR_EN
  logic stop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 stop_q <= 1'b0;
    else if (branch_i)          stop_q <= 1'b0;
    else if (push && resp_err_i) stop_q <= 1'b1;
  end

  assign stop = stop_q;
`else
  assign stop = 1'b0;
`endif

  assign credit_used   = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign trans_valid_o = prefetch_en_i && started_q && !branch_i && !stop
                         && (credit_used < (CW+1)'(DEPTH));
  assign trans_addr_o  = addr_q;
  assign accept        = trans_valid_o && trans_ready_i;
  assign outst_next    = outst_q + CW'(accept) - CW'(resp_valid_i);
  assign push          = resp_valid_i && (discard_q == '0) && !branch_i;
  assign pop           = fetch_valid_o && fetch_ready_i && !branch_i;
  assign push_entry    = '{rdata: resp_rdata_i, addr: iaq_q[iaq_rd_q], err: resp_err_i};
  assign busy_o        = (outst_q != '0) || (discard_q != '0);

  // Responses return in order, so every response (kept or dropped) retires the oldest issue address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      started_q <= 1'b0;
      outst_q   <= '0;
      discard_q <= '0;
      iaq_wr_q  <= '0;
      iaq_rd_q  <= '0;
    end else begin
      outst_q <= outst_next;
      if (accept) begin
        addr_q   <= addr_q + 32'd4;
        iaq_wr_q <= AW'(wrap_inc(32'(iaq_wr_q), DEPTH));
      end
      if (resp_valid_i) iaq_rd_q <= AW'(wrap_inc(32'(iaq_rd_q), DEPTH));
      // Everything still in flight once this cycle settles belongs to the old stream.
      if (branch_i) begin
        addr_q    <= word_align(branch_addr_i);
        started_q <= 1'b1;
        discard_q <= outst_next;
      end else if (resp_valid_i && (discard_q != '0)) begin
        discard_q <= discard_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) iaq_q[iaq_wr_q] <= addr_q;
  end

  cv32e40s_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (branch_i),
    .head      (head),
    .cnt       (fifo_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign fetch_valid_o = !fifo_empty;
  assign fetch_rdata_o = head.rdata;
  assign fetch_addr_o  = head.addr;
  assign fetch_err_o   = head.err;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) resp_valid_i |-> (outst_q != '0));
  a_credit_max:   assert property (@(posedge clk) disable iff (!rst_n) accept |-> (credit_used < (CW+1)'(DEPTH)));

endmodule

// File: tb/tb_cv32e40s_fetch_req_ctrl.sv
// Directed bench for cv32e40s_fetch_req_ctrl with an in-order OBI adapter model and a fetch scoreboard.
module tb_cv32e40s_fetch_req_ctrl;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        prefetch_en_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        trans_valid_o;
  logic        trans_ready_i;
  logic [31:0] trans_addr_o;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;
  logic        resp_err_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_err_o;
  logic        busy_o;

  cv32e40s_fetch_req_ctrl #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .prefetch_en_i (prefetch_en_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .trans_valid_o (trans_valid_o),
    .trans_ready_i (trans_ready_i),
    .trans_addr_o  (trans_addr_o),
    .resp_valid_i  (resp_valid_i),
    .resp_rdata_i  (resp_rdata_i),
    .resp_err_i    (resp_err_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_rdata_o (fetch_rdata_o),
    .fetch_addr_o  (fetch_addr_o),
    .fetch_err_o   (fetch_err_o),
    .busy_o        (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          cyc;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  pend_t       pend_q[$];
  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_accepts = 0;
  int          hold_cycles = 0;
  int          acc_base = 0;
  bit          resp_en = 1'b1;
  bit          m_started = 1'b0;
  bit          m_stop = 1'b0;
  bit          arm_first = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] err_addr = NO_ERR;
  logic [31:0] first_kept = 32'h0;
  logic [31:0] seen_err_addr = 32'h0;
  logic [31:0] last_accept = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the adapter response, check outputs mid-cycle, update the model.
  task automatic tick();
    exp_t  e;
    pend_t p;
    logic  exp_tv;
    if (resp_en && pend_q.size() != 0 && pend_q[0].cyc < cyc) begin
      resp_valid_i = 1'b1;
      resp_rdata_i = mem_data(pend_q[0].addr);
      resp_err_i   = (pend_q[0].addr == err_addr);
    end else begin
      resp_valid_i = 1'b0;
      resp_rdata_i = 32'h0;
      resp_err_i   = 1'b0;
    end
    #5;
    exp_tv = prefetch_en_i && m_started && !branch_i && !m_stop
             && (pend_q.size() + sb_q.size() < DEPTH);
    chk("busy", 32'(busy_o), 32'(pend_q.size() != 0));
    chk("trans_valid", 32'(trans_valid_o), 32'(exp_tv));
    if (trans_valid_o) chk("trans_addr", trans_addr_o, exp_addr);
    chk("fetch_valid", 32'(fetch_valid_o), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      chk("fetch_addr", fetch_addr_o, sb_q[0].addr);
      chk("fetch_rdata", fetch_rdata_o, sb_q[0].rdata);
      chk("fetch_err", 32'(fetch_err_o), 32'(sb_q[0].err));
    end
    if (fetch_ready_i && !branch_i && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (arm_first) begin
        first_kept = e.addr;
        arm_first  = 1'b0;
      end
      if (e.err) seen_err_addr = e.addr;
    end
    if (resp_valid_i) begin
      p = pend_q.pop_front();
      if (!p.stale && !branch_i) begin
        sb_q.push_back('{addr: p.addr, rdata: mem_data(p.addr), err: (p.addr == err_addr)});
`ifdef CV32E40S_FETCH_STOP_ON_ERR_EN
        if (p.addr == err_addr) m_stop = 1'b1;
`endif
      end
    end
    if (branch_i) begin
      sb_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      m_started = 1'b1;
      m_stop    = 1'b0;
      exp_addr  = branch_addr_i & 32'hFFFF_FFFC;
    end
    if (trans_valid_o && trans_ready_i) begin
      n_accepts++;
      last_accept = exp_addr;
      pend_q.push_back('{addr: exp_addr, stale: 1'b0, cyc: cyc});
      exp_addr = exp_addr + 32'd4;
      chk("outstanding_max", 32'(pend_q.size() <= DEPTH), 32'd1);
    end
    if (trans_valid_o && !trans_ready_i) hold_cycles++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_addr_i = a;
    branch_i      = 1'b1;
    tick();
    branch_i      = 1'b0;
    branch_addr_i = 32'h0;
  endtask

  task automatic do_reset();
    resp_valid_i = 1'b0;
    resp_rdata_i = 32'h0;
    resp_err_i   = 1'b0;
    rst_n        = 1'b0;
    pend_q.delete();
    sb_q.delete();
    m_started = 1'b0;
    m_stop    = 1'b0;
    exp_addr  = 32'h0;
    #5;
    chk("rst_trans_valid", 32'(trans_valid_o), 32'd0);
    chk("rst_trans_addr", trans_addr_o, 32'h0);
    chk("rst_fetch_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_fetch_rdata", fetch_rdata_o, 32'h0);
    chk("rst_fetch_addr", fetch_addr_o, 32'h0);
    chk("rst_fetch_err", 32'(fetch_err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_addr(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget && exp_addr != target; i++) tick();
    chk("reach_addr", exp_addr, target);
  endtask

  task automatic run_until_first(input logic [31:0] target, input int budget);
    arm_first  = 1'b1;
    first_kept = 32'hFFFF_FFFF;
    for (int i = 0; i < budget && arm_first; i++) tick();
    chk("first_kept", first_kept, target);
    arm_first = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    prefetch_en_i = 1'b1;
    branch_i      = 1'b0;
    branch_addr_i = 32'h0;
    trans_ready_i = 1'b1;
    fetch_ready_i = 1'b1;
    resp_valid_i  = 1'b0;
    resp_rdata_i  = 32'h0;
    resp_err_i    = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Not started: no requests before the first branch.
    ticks(3);

    // 1: boot branch (low address bits ignored), streaming with one-cycle responses.
    do_branch(32'h0000_0103);
    run_until_addr(32'h108, 20);

    // 2: adapter stalls while 0x108 is pending; request must be held stable.
    hold_cycles   = 0;
    trans_ready_i = 1'b0;
    ticks(5);
    trans_ready_i = 1'b1;
    chk("hold_cycles", 32'(hold_cycles >= 3), 32'd1);
    ticks(6);

    // 3: two outstanding, branch away; both old responses dropped.
    resp_en = 1'b0;
    ticks(4);
    chk("two_outst_busy", 32'(busy_o), 32'd1);
    chk("two_outst_no_req", 32'(trans_valid_o), 32'd0);
    do_branch(32'h0000_0200);
    resp_en = 1'b1;
    run_until_first(32'h200, 15);
    ticks(4);

    // 4: branch coincides with a response.
    resp_en = 1'b0;
    ticks(4);
    resp_en = 1'b1;
    do_branch(32'h0000_0200);
    run_until_first(32'h200, 15);
    ticks(4);

    // 5: consumer stalls; credit stops requests, one pop frees exactly one request.
    fetch_ready_i = 1'b0;
    ticks(6);
    chk("stall_no_req", 32'(trans_valid_o), 32'd0);
    chk("stall_head_valid", 32'(fetch_valid_o), 32'd1);
    fetch_ready_i = 1'b1;
    tick();
    fetch_ready_i = 1'b0;
    acc_base = n_accepts;
    ticks(6);
    chk("one_pop_one_req", 32'(n_accepts - acc_base), 32'd1);
    fetch_ready_i = 1'b1;
    ticks(4);

    // 6: bus error on 0x10C.
    err_addr = 32'h10C;
    do_branch(32'h0000_0100);
    ticks(12);
    chk("err_seen_addr", seen_err_addr, 32'h10C);
`ifdef CV32E40S_FETCH_STOP_ON_ERR_EN
    chk("err_stop_last", last_accept, 32'h10C);
    chk("err_stop_idle", 32'(busy_o), 32'd0);
`else
    chk("err_continue", 32'(last_accept >= 32'h110), 32'd1);
`endif
    err_addr = NO_ERR;
    do_branch(32'h0000_0400);
    run_until_addr(32'h408, 10);
    ticks(2);

    // 7: reset while streaming, then restart.
    do_reset();
    ticks(3);
    do_branch(32'h0000_0500);
    run_until_addr(32'h50C, 15);
    ticks(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
